cpl_tracker: RTL and testbench
==============================

// Module: cpl_tracker
// PURPOSE
//  Completion tracker sitting directly downstream of the tag manager in req_cpl.
//  Records each issued read request (tag and byte length) and consumes split completions.
//  On the final completion, or on error or timeout, it retires the tag and returns it to the tag manager.
//  Drives the tag manager's push/tag_in recycle interface.
// PARAMETERS
//  TAG_NUM       8     tracked tags (power of 2, 2..256); index = tag[log2(TAG_NUM)-1:0]
//  LEN_W         13    byte-length width (1..4096 bytes)
//  TICK_DIV      1024  clk cycles per timeout tick
//  TIMEOUT_TICKS 15    ticks before an outstanding tag expires (1..15, 4-bit age)
// PORTS
//  clk          in   1      clock
//  rst_n        in   1      reset, asynchronous, active-low
//  alloc_vld    in   1      request issued this cycle with alloc_tag
//  alloc_tag    in   8      tag from tag manager tag_out
//  alloc_len    in   LEN_W  total bytes requested (0 illegal)
//  cpl_vld      in   1      completion TLP received
//  cpl_tag      in   8      completion tag
//  cpl_bytes    in   LEN_W  payload bytes in this completion
//  cpl_err      in   1      completion status != SC (UR/CA)
//  release_vld  out  1      to tag manager push; 1-cycle pulse
//  release_tag  out  8      to tag manager tag_in
//  done_err     out  1      qualifies release: 1 = error, timeout or overrun
//  unexp_cpl    out  1      pulse: completion for a non-outstanding tag
//  outst_cnt    out  log2(TAG_NUM)+1  number of outstanding tags
// BEHAVIOUR
//  - Reset: all entries invalid; release_vld, release_tag, done_err, unexp_cpl = 0; outst_cnt = 0.
//  - Entry per tag: vld, remain[LEN_W-1:0], age[3:0]. alloc_vld sets vld, remain = alloc_len, age = 0.
//  - Completion to a valid entry:
//    - cpl_err = 1: final, with err.
//    - cpl_bytes > remain: final, with err (overrun).
//    - cpl_bytes == remain: final, no err.
//    - Otherwise remain -= cpl_bytes and age = 0.
//  - Final completion clears vld in the same edge. release_vld/release_tag/done_err are registered
//    and assert the cycle after cpl_vld (1-cycle latency).
//  - Completion to an invalid entry: table unchanged, unexp_cpl pulses the next cycle, no release.
//  - At most one release per cycle. Completion release beats timeout release.
//  - outst_cnt is registered: +1 on alloc, -1 on any retire, net 0 when both occur in the same cycle.
//  - Alloc to an already-valid tag is a protocol violation: it overwrites the entry; the SVA flags it.
//  - Alloc and final completion on the same tag in the same cycle cannot occur, because the tag
//    manager only re-issues a tag after release.
//  - Reset mid-operation discards all entries and does not issue releases. The tag manager resets
//    in the same domain, so tag state stays consistent.
// CONFIGURATION
//  CPL_TIMEOUT_EN defined:
//    - Free-running prescaler produces a tick every TICK_DIV cycles.
//    - On each tick, every valid entry with age < TIMEOUT_TICKS increments its age.
//    - An entry with age == TIMEOUT_TICKS is expired. The lowest-index expired entry is retired in
//      any cycle with no completion release: vld cleared, release pulse with done_err = 1.
//  CPL_TIMEOUT_EN undefined:
//    - No prescaler, no age bits. Entries wait indefinitely; releases come only from completions.
// STRUCTURE
//  - Shared header req_cpl_defs.vh (included next to common_funcs.vh) holds:
//    CPL_ST_SC/UR/CA status codes, default LEN_W, MAX_READ_BYTES = 4096.
//  - One sub-module: cpl_age_timer (prescaler plus per-entry age/expire vector), instantiated only
//    under CPL_TIMEOUT_EN.
//  - Expired-entry selection reuses right_find_1st_one and onehot_to_binary.
// TESTING
//  1. alloc tag 3, len 256; one cpl 256 bytes -> next cycle release_vld = 1, release_tag = 3,
//     done_err = 0; outst_cnt 1 -> 0.
//  2. alloc tag 5, len 512; cpl 128, 128, 256 -> no release after the first two;
//     release tag 5 only after the third.
//  3. cpl to tag 2 with nothing outstanding -> unexp_cpl pulse; no release; outst_cnt unchanged.
//  4. alloc tag 1, len 64; cpl_err = 1 with 32 bytes -> release tag 1, done_err = 1;
//     a later cpl to tag 1 -> unexp_cpl.
//  5. Same cycle: alloc tag 6, and final cpl for tag 0 -> outst_cnt unchanged; release tag 0;
//     tag 6 remains valid.
//  6. CPL_TIMEOUT_EN, TICK_DIV = 4, TIMEOUT_TICKS = 2: alloc tags 0 and 1, no cpl -> tag 0
//     released, then tag 1 next cycle, both done_err = 1; a completion arriving in the same cycle
//     wins first.

Source files
------------

// File: rtl/cpl_tracker_pkg.sv
// Shared definitions for the read-completion tracker: status codes, size
// limits and the lowest-set-bit / one-hot encoder helpers used for the
// expired-entry selection.
package cpl_tracker_pkg;

  localparam int DEF_LEN_W      = 13;
  localparam int MAX_READ_BYTES = 4096;
  localparam int MAX_TAGS       = 256;

  typedef enum logic [2:0] {
    CPL_ST_SC = 3'b000,
    CPL_ST_UR = 3'b001,
    CPL_ST_CA = 3'b100
  } cpl_st_e;

  // Isolate the lowest set bit of a request vector.
  function automatic logic [MAX_TAGS-1:0] right_find_1st_one(input logic [MAX_TAGS-1:0] v);
    return v & (~v + {{(MAX_TAGS-1){1'b0}}, 1'b1});
  endfunction

  // Encode a one-hot vector into a tag-wide binary index.
  function automatic logic [7:0] onehot_to_binary(input logic [MAX_TAGS-1:0] oh);
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < MAX_TAGS; i++) begin
      if (oh[i]) b = b | 8'(i);
    end
    return b;
  endfunction

endpackage

// File: rtl/cpl_tracker_if.sv
// Request/completion/release bundle between the tag manager side (master)
// and the completion tracker (slave).
interface cpl_tracker_if
  import cpl_tracker_pkg::*;
#(
  parameter int TAG_NUM = 8,
  parameter int LEN_W   = DEF_LEN_W
);
  localparam int CNT_W = $clog2(TAG_NUM) + 1;

  logic             alloc_vld;
  logic [7:0]       alloc_tag;
  logic [LEN_W-1:0] alloc_len;
  logic             cpl_vld;
  logic [7:0]       cpl_tag;
  logic [LEN_W-1:0] cpl_bytes;
  logic             cpl_err;
  logic             release_vld;
  logic [7:0]       release_tag;
  logic             done_err;
  logic             unexp_cpl;
  logic [CNT_W-1:0] outst_cnt;

  modport master (
    output alloc_vld, alloc_tag, alloc_len, cpl_vld, cpl_tag, cpl_bytes, cpl_err,
    input  release_vld, release_tag, done_err, unexp_cpl, outst_cnt
  );

  modport slave (
    input  alloc_vld, alloc_tag, alloc_len, cpl_vld, cpl_tag, cpl_bytes, cpl_err,
    output release_vld, release_tag, done_err, unexp_cpl, outst_cnt
  );

endinterface

// File: rtl/cpl_tracker_age_timer.sv
// Timeout prescaler plus per-entry 4-bit age counters (module cpl_age_timer).
// Only instantiated when CPL_TIMEOUT_EN is defined.
module cpl_age_timer #(
  parameter int TAG_NUM       = 8,
  parameter int TICK_DIV      = 1024,
  parameter int TIMEOUT_TICKS = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [TAG_NUM-1:0] vld,
  input  logic [TAG_NUM-1:0] clr,
  output logic [TAG_NUM-1:0] expired
);
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [DIV_W-1:0] div_p0;
  logic             tick;
  logic [3:0]       age_p0 [TAG_NUM];

  assign tick = (div_p0 == DIV_W'(TICK_DIV - 1));

  // free-running prescaler, one tick every TICK_DIV cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    div_p0 <= '0;
    else if (tick) div_p0 <= '0;
    else           div_p0 <= div_p0 + 1'b1;
  end

  // ages restart on allocation or partial completion and saturate at the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAG_NUM; i++) age_p0[i] <= '0;
    end else begin
      for (int i = 0; i < TAG_NUM; i++) begin
        if (clr[i] || !vld[i])
          age_p0[i] <= '0;
        else if (tick && (age_p0[i] < 4'(TIMEOUT_TICKS)))
          age_p0[i] <= age_p0[i] + 4'd1;
      end
    end
  end

  // an entry is expired once its age has reached the limit
  always_comb begin
    expired = '0;
    for (int i = 0; i < TAG_NUM; i++)
      expired[i] = vld[i] && (age_p0[i] == 4'(TIMEOUT_TICKS));
  end

endmodule

// File: rtl/cpl_tracker.sv
// Completion tracker: records issued read tags with their byte length,
// consumes split completions and returns retired tags to the tag manager.
// Optional feature macro: CPL_TIMEOUT_EN (adds age-based tag expiry).
module cpl_tracker
  import cpl_tracker_pkg::*;
#(
  parameter int TAG_NUM = 8,
  parameter int LEN_W   = DEF_LEN_W
`ifdef CPL_TIMEOUT_EN
  ,
  parameter int TICK_DIV      = 1024,
  parameter int TIMEOUT_TICKS = 15
`endif
) (
  input logic          clk,
  input logic          rst_n,
  cpl_tracker_if.slave bus
);
  localparam int IDX_W = $clog2(TAG_NUM);
  localparam int CNT_W = IDX_W + 1;

  logic [TAG_NUM-1:0] vld_p0;
  logic [LEN_W-1:0]   remain_p0 [TAG_NUM];
  logic [IDX_W-1:0]   alloc_idx;
  logic [IDX_W-1:0]   cpl_idx;
  logic               cpl_hit;
  logic               cpl_final;
  logic               cpl_fin_err;
  logic               cpl_unexp;
  logic               to_fire;
  logic [7:0]         to_tag;
  logic               retire;

  logic               release_vld_p1;
  logic [7:0]         release_tag_p1;
  logic               done_err_p1;
  logic               unexp_cpl_p1;
  logic [CNT_W-1:0]   outst_cnt_p1;

  assign alloc_idx = bus.alloc_tag[IDX_W-1:0];
  assign cpl_idx   = bus.cpl_tag[IDX_W-1:0];

  // classify the incoming completion against the current table contents
  always_comb begin
    cpl_hit     = bus.cpl_vld && vld_p0[cpl_idx];
    cpl_unexp   = bus.cpl_vld && !vld_p0[cpl_idx];
    cpl_final   = cpl_hit && (bus.cpl_err || (bus.cpl_bytes >= remain_p0[cpl_idx]));
    cpl_fin_err = bus.cpl_err || (bus.cpl_bytes > remain_p0[cpl_idx]);
  end

`ifdef CPL_TIMEOUT_EN
  logic [TAG_NUM-1:0] age_clr;
  logic [TAG_NUM-1:0] expired;
  logic [TAG_NUM-1:0] exp_cand;

  // allocation and any completion hit restart the entry's age
  always_comb begin
    age_clr = '0;
    if (bus.alloc_vld) age_clr[alloc_idx] = 1'b1;
    if (cpl_hit)       age_clr[cpl_idx]   = 1'b1;
  end

  cpl_age_timer #(
    .TAG_NUM      (TAG_NUM),
    .TICK_DIV     (TICK_DIV),
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) u_age_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .vld    (vld_p0),
    .clr    (age_clr),
    .expired(expired)
  );

  // pick the lowest expired entry; the completion slot always has priority,
  // and an entry being completed this cycle is not also timed out
  always_comb begin
    exp_cand = expired;
    if (cpl_hit) exp_cand[cpl_idx] = 1'b0;
    to_fire = (|exp_cand) && !cpl_final;
    to_tag  = onehot_to_binary(right_find_1st_one(MAX_TAGS'(exp_cand)));
  end
`else
  assign to_fire = 1'b0;
  assign to_tag  = '0;
`endif

  assign retire = cpl_final || to_fire;

  // entry valid bits: set on allocation, cleared on completion or timeout retire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= '0;
    end else begin
      if (cpl_final)    vld_p0[cpl_idx]            <= 1'b0;
      else if (to_fire) vld_p0[to_tag[IDX_W-1:0]]  <= 1'b0;
      if (bus.alloc_vld) vld_p0[alloc_idx]         <= 1'b1;
    end
  end

  // remaining byte counts; only meaningful while the entry is valid
  always_ff @(posedge clk) begin
    if (cpl_hit && !cpl_final) remain_p0[cpl_idx]   <= remain_p0[cpl_idx] - bus.cpl_bytes;
    if (bus.alloc_vld)         remain_p0[alloc_idx] <= bus.alloc_len;
  end

  // ---- stage p1: registered release / status outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      release_vld_p1 <= 1'b0;
      release_tag_p1 <= '0;
      done_err_p1    <= 1'b0;
      unexp_cpl_p1   <= 1'b0;
      outst_cnt_p1   <= '0;
    end else begin
      release_vld_p1 <= retire;
      release_tag_p1 <= cpl_final ? bus.cpl_tag : (to_fire ? to_tag : 8'd0);
      done_err_p1    <= cpl_final ? cpl_fin_err : to_fire;
      unexp_cpl_p1   <= cpl_unexp;
      outst_cnt_p1   <= outst_cnt_p1 + CNT_W'(bus.alloc_vld) - CNT_W'(retire);
    end
  end

  assign bus.release_vld = release_vld_p1;
  assign bus.release_tag = release_tag_p1;
  assign bus.done_err    = done_err_p1;
  assign bus.unexp_cpl   = unexp_cpl_p1;
  assign bus.outst_cnt   = outst_cnt_p1;

  // the tag manager must never hand out a tag that is still outstanding
  a_alloc_free : assert property (@(posedge clk) disable iff (!rst_n)
    bus.alloc_vld |-> !vld_p0[alloc_idx]);

  // allocated tags must fit the table and requests must carry bytes
  a_alloc_legal : assert property (@(posedge clk) disable iff (!rst_n)
    bus.alloc_vld |-> (({24'd0, bus.alloc_tag} < 32'(TAG_NUM)) && (bus.alloc_len != '0)));

endmodule

// File: tb/tb_cpl_tracker.sv
// Bench for cpl_tracker: directed vector table, randomized traffic against a
// byte-count reference model, reset-mid-operation and (with CPL_TIMEOUT_EN)
// expiry ordering sequences.
module tb_cpl_tracker;
  localparam int TAG_NUM = 8;
  localparam int LEN_W   = 13;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  cpl_tracker_if #(.TAG_NUM(TAG_NUM), .LEN_W(LEN_W)) bus ();

  cpl_tracker #(
    .TAG_NUM(TAG_NUM),
    .LEN_W  (LEN_W)
`ifdef CPL_TIMEOUT_EN
    ,
    .TICK_DIV     (4),
    .TIMEOUT_TICKS(2)
`endif
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       av;
    logic [7:0] at;
    int         al;
    logic       cv;
    logic [7:0] ct;
    int         cb;
    logic       ce;
    logic       rv;
    logic [7:0] rt;
    logic       de;
    logic       ue;
    int         cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [7:0] at, input int al,
                       input logic cv, input logic [7:0] ct, input int cb, input logic ce);
    bus.alloc_vld = av;
    bus.alloc_tag = at;
    bus.alloc_len = LEN_W'(al);
    bus.cpl_vld   = cv;
    bus.cpl_tag   = ct;
    bus.cpl_bytes = LEN_W'(cb);
    bus.cpl_err   = ce;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reset is released at a falling edge, so the next rising edge is cycle 1
  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic vec_t mkv(string nm, logic av, int at, int al, logic cv, int ct, int cb,
                               logic ce, logic rv, int rt, logic de, logic ue, int cnt);
    vec_t v;
    v.name = nm; v.av = av; v.at = 8'(at); v.al = al;
    v.cv = cv; v.ct = 8'(ct); v.cb = cb; v.ce = ce;
    v.rv = rv; v.rt = 8'(rt); v.de = de; v.ue = ue; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk_out(input string nm, input logic rv, input logic [7:0] rt,
                         input logic de, input logic ue, input int cnt);
    chk({nm, ".release_vld"}, int'(bus.release_vld), int'(rv));
    if (rv) begin
      chk({nm, ".release_tag"}, int'(bus.release_tag), int'(rt));
      chk({nm, ".done_err"}, int'(bus.done_err), int'(de));
    end
    chk({nm, ".unexp_cpl"}, int'(bus.unexp_cpl), int'(ue));
    chk({nm, ".outst_cnt"}, int'(bus.outst_cnt), cnt);
  endtask

  // reference model state: outstanding flag and bytes still owed per tag
  bit         mvld [TAG_NUM];
  int         mrem [TAG_NUM];
  int         mcnt;
  logic       r_av, r_cv, r_ce, e_rv, e_de, e_ue;
  logic [7:0] r_at, r_ct;
  int         r_al, r_cb, pick;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("async_reset.release_vld", int'(bus.release_vld), 0);
    chk("async_reset.outst_cnt", int'(bus.outst_cnt), 0);

    do_reset();
    chk("reset.release_vld", int'(bus.release_vld), 0);
    chk("reset.release_tag", int'(bus.release_tag), 0);
    chk("reset.done_err", int'(bus.done_err), 0);
    chk("reset.unexp_cpl", int'(bus.unexp_cpl), 0);
    chk("reset.outst_cnt", int'(bus.outst_cnt), 0);

    //                  name        av at  al  cv ct  cb  ce  rv rt de ue cnt
    vecs.push_back(mkv("t1_alloc",  1, 3, 256, 0, 0, 0,   0,  0, 0, 0, 0, 1));
    vecs.push_back(mkv("t1_cpl",    0, 0, 0,   1, 3, 256, 0,  1, 3, 0, 0, 0));
    vecs.push_back(mkv("t2_alloc",  1, 5, 512, 0, 0, 0,   0,  0, 0, 0, 0, 1));
    vecs.push_back(mkv("t2_cpl1",   0, 0, 0,   1, 5, 128, 0,  0, 0, 0, 0, 1));
    vecs.push_back(mkv("t2_cpl2",   0, 0, 0,   1, 5, 128, 0,  0, 0, 0, 0, 1));
    vecs.push_back(mkv("t2_cpl3",   0, 0, 0,   1, 5, 256, 0,  1, 5, 0, 0, 0));
    vecs.push_back(mkv("t3_unexp",  0, 0, 0,   1, 2, 16,  0,  0, 0, 0, 1, 0));
    vecs.push_back(mkv("t3_idle",   0, 0, 0,   0, 0, 0,   0,  0, 0, 0, 0, 0));
    vecs.push_back(mkv("t4_alloc",  1, 1, 64,  0, 0, 0,   0,  0, 0, 0, 0, 1));
    vecs.push_back(mkv("t4_err",    0, 0, 0,   1, 1, 32,  1,  1, 1, 1, 0, 0));
    vecs.push_back(mkv("t4_late",   0, 0, 0,   1, 1, 32,  0,  0, 0, 0, 1, 0));
    vecs.push_back(mkv("t5_alloc0", 1, 0, 100, 0, 0, 0,   0,  0, 0, 0, 0, 1));
    vecs.push_back(mkv("t5_same",   1, 6, 50,  1, 0, 100, 0,  1, 0, 0, 0, 1));
    vecs.push_back(mkv("t5_ovrun6", 0, 0, 0,   1, 6, 60,  0,  1, 6, 1, 0, 0));
    vecs.push_back(mkv("t5_idle",   0, 0, 0,   0, 0, 0,   0,  0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].av, vecs[i].at, vecs[i].al, vecs[i].cv, vecs[i].ct, vecs[i].cb, vecs[i].ce);
      step();
      chk_out(vecs[i].name, vecs[i].rv, vecs[i].rt, vecs[i].de, vecs[i].ue, vecs[i].cnt);
    end
    drive(0, 0, 0, 0, 0, 0, 0);

`ifndef CPL_TIMEOUT_EN
    // randomized traffic; the table is empty after the vectors above
    for (int t = 0; t < TAG_NUM; t++) begin
      mvld[t] = 1'b0;
      mrem[t] = 0;
    end
    mcnt = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      r_av = 0; r_at = 0; r_al = 0; r_cv = 0; r_ct = 0; r_cb = 0; r_ce = 0;
      if ($urandom_range(0, 99) < 40) begin
        pick = $urandom_range(0, TAG_NUM - 1);
        if (!mvld[pick]) begin
          r_av = 1; r_at = 8'(pick); r_al = $urandom_range(1, 4096);
        end
      end
      if ($urandom_range(0, 99) < 60) begin
        pick = $urandom_range(0, TAG_NUM - 1);
        r_cv = 1; r_ct = 8'(pick);
        if (mvld[pick]) begin
          case ($urandom_range(0, 9))
            0:       begin r_ce = 1; r_cb = $urandom_range(1, 64); end
            1:       r_cb = mrem[pick] + $urandom_range(1, 100);
            2, 3, 4: r_cb = mrem[pick];
            default: r_cb = (mrem[pick] > 1) ? $urandom_range(1, mrem[pick] - 1) : mrem[pick];
          endcase
        end else begin
          r_cb = $urandom_range(1, 64);
        end
      end

      e_rv = 0; e_de = 0;
      e_ue = r_cv && !mvld[r_ct];
      if (r_cv && mvld[r_ct]) begin
        if (r_ce || r_cb >= mrem[r_ct]) begin
          e_rv = 1;
          e_de = r_ce || (r_cb > mrem[r_ct]);
          mvld[r_ct] = 0;
          mcnt--;
        end else begin
          mrem[r_ct] = mrem[r_ct] - r_cb;
        end
      end
      if (r_av) begin
        mvld[r_at] = 1;
        mrem[r_at] = r_al;
        mcnt++;
      end

      drive(r_av, r_at, r_al, r_cv, r_ct, r_cb, r_ce);
      step();
      chk_out("rand", e_rv, r_ct, e_de, e_ue, mcnt);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
`endif

    // reset while tags are outstanding discards them without releases
    do_reset();
    drive(1, 2, 40, 0, 0, 0, 0);
    step();
    chk("midrst.pre_cnt", int'(bus.outst_cnt), 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #2;
    chk("midrst.cnt", int'(bus.outst_cnt), 0);
    chk("midrst.release_vld", int'(bus.release_vld), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 1, 2, 40, 0);
    step();
    chk_out("midrst.cpl_after", 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0);

`ifdef CPL_TIMEOUT_EN
    // tags 0 and 1 expire on the same tick; lowest index retires first
    do_reset();
    for (int c = 1; c <= 11; c++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      if (c == 1) drive(1, 0, 16, 0, 0, 0, 0);
      if (c == 2) drive(1, 1, 16, 0, 0, 0, 0);
      step();
      if (c == 9)       chk_out("to_a.c9", 1, 0, 1, 0, 1);
      else if (c == 10) chk_out("to_a.c10", 1, 1, 1, 0, 0);
      else if (c >= 2)  chk({"to_a.quiet"}, int'(bus.release_vld), 0);
    end

    // a completion in the expiry cycle goes first, timeouts follow in order
    do_reset();
    for (int c = 1; c <= 11; c++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      if (c == 1) drive(1, 0, 16, 0, 0, 0, 0);
      if (c == 2) drive(1, 1, 16, 0, 0, 0, 0);
      if (c == 3) drive(1, 4, 8, 0, 0, 0, 0);
      if (c == 9) drive(0, 0, 0, 1, 4, 8, 0);
      step();
      if (c == 3)       chk("to_b.cnt3", int'(bus.outst_cnt), 3);
      if (c == 9)       chk_out("to_b.c9", 1, 4, 0, 0, 2);
      else if (c == 10) chk_out("to_b.c10", 1, 0, 1, 0, 1);
      else if (c == 11) chk_out("to_b.c11", 1, 1, 1, 0, 0);
      else              chk("to_b.quiet", int'(bus.release_vld), 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
